sb_rr_arbiter: RTL
==================

Name: sb_rr_arbiter

Overview:
- Shares one system-bus slave (e.g. the timer/peripheral controller) between N bus masters (core LSU, debug/DMA port).
- Round-robin arbitration; the granted command is latched for the whole transaction; response is routed back to the winner.
- Watchdog timeout returns an error response if the slave never asserts ready.
- Sits between the masters' system-bus ports and a single slave with the req/we/addr/wdata -> rdata/ready interface.

Parameters:
- N_MASTERS, 2, number of requesting masters (2..8)
- TIMEOUT, 255, BUSY cycles without s_ready_i before an error response; 0 disables the timeout
- ERR_DATA, 32'hDEAD_BEEF, read data returned on timeout

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- m_req_i  in  N_MASTERS  per-master request, held until its m_ready_o
- m_we_i  in  N_MASTERS  per-master write enable
- m_addr_i  in  N_MASTERS x 32  per-master address
- m_wdata_i  in  N_MASTERS x 32  per-master write data
- m_rdata_o  out  N_MASTERS x 32  per-master read data, valid with m_ready_o
- m_ready_o  out  N_MASTERS  one-cycle completion pulse
- m_err_o  out  N_MASTERS  asserted with m_ready_o on timeout
- s_req_o  out  1  slave request
- s_we_o  out  1  slave write enable
- s_addr_o  out  32  slave address
- s_wdata_o  out  32  slave write data
- s_rdata_i  in  32  slave read data
- s_ready_i  in  1  slave completion
- grant_o  out  $clog2(N_MASTERS)  index of the current or last granted master
- busy_o  out  1  transaction in flight

Behaviour:
- Reset (rst_ni=0 at clk edge):
  - state=IDLE; last_grant=N_MASTERS-1, so master 0 wins first; timeout counter=0.
  - All outputs 0. Any in-flight transaction is dropped and no m_ready_o is issued.
- IDLE:
  - s_req_o, s_we_o, s_addr_o, s_wdata_o are driven to 0, so no slave decodes a phantom access.
  - If any m_req_i is high, pick the first requester searching upward from (last_grant+1) mod N_MASTERS with wrap-around.
  - Latch that master's we/addr/wdata and the grant index; go to BUSY at the next edge.
  - Any m_req_i high in IDLE is a new request.
- BUSY:
  - s_req_o=1; s_we_o, s_addr_o, s_wdata_o come from the latched command.
  - Master input changes or req withdrawal are ignored until completion.
  - On s_ready_i=1: in the same cycle, m_ready_o[g]=1 and m_rdata_o[g]=s_rdata_i (combinational pass-through). Set last_grant=g and go to IDLE.
  - Timeout (TIMEOUT>0): the counter increments each BUSY cycle without s_ready_i. In the TIMEOUT-th such cycle, m_ready_o[g]=1, m_err_o[g]=1, m_rdata_o[g]=ERR_DATA; set last_grant=g and go to IDLE.
  - s_ready_i arriving in the timeout cycle takes precedence: normal response, no error.
- Non-granted masters: m_ready_o=0, m_err_o=0, m_rdata_o=0 at all times.
- Latency: request seen in IDLE at cycle t -> s_req_o at t+1 -> earliest m_ready_o at t+1 (zero-wait slave). Minimum one IDLE cycle between back-to-back transactions.
- s_ready_i in IDLE is ignored.
- busy_o = (state==BUSY).
- Fairness: with all masters requesting continuously, grants rotate 0,1,...,N-1,0.

Decomposition:
- Package sb_arb_pkg:
  - state enum {IDLE, BUSY}
  - default ERR_DATA constant
  - bus command struct {we, addr, wdata}
- One combinational sub-module, rr_picker: inputs req vector and last_grant; outputs any_req and next index.

Test Plan:
- Single master 0: write addr 32'h08, data 32'd100, zero-wait slave -> s_req_o/s_addr_o=32'h08 one cycle after request; m_ready_o[0] pulses in that same cycle; m_err_o=0.
- Both masters request at cycle 0, kept asserted -> grants 0,1,0,1 in order; each transaction 2 cycles (BUSY + IDLE).
- Master 1 read addr 32'h00 with slave returning 32'h1234 after 3 wait cycles; master 1 changes m_addr_i mid-transaction -> s_addr_o stays 32'h00; m_rdata_o[1]=32'h1234 with m_ready_o[1]; m_ready_o[0] stays 0.
- Slave never ready, TIMEOUT=4 -> m_ready_o[g] and m_err_o[g] high on the 4th BUSY cycle with m_rdata_o=32'hDEAD_BEEF; state returns to IDLE.
- s_ready_i asserted exactly in the 4th BUSY cycle (TIMEOUT=4) -> normal response with slave data; m_err_o=0.
- rst_ni low during BUSY -> next cycle all outputs 0, no m_ready_o; after release, master 0 is granted first.

Source files
------------

// File: rtl/sb_arb_pkg.sv
// Shared types and constants for the system-bus round-robin arbiter.
package sb_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  // Read data returned to a master whose transaction timed out.
  localparam logic [DATA_W-1:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  // Arbiter FSM: IDLE picks a winner, BUSY holds the command on the slave.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  // Command captured from the winning master for the whole transaction.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_cmd_t;

  // Width of a master index; at least one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sb_rr_arbiter_rr_picker.sv
// Round-robin winner search: first requester above the last grant, wrapping.
module rr_picker
  import sb_arb_pkg::*;
#(
  parameter int N_MASTERS = 2,
  localparam int GW = idx_width(N_MASTERS)
) (
  input  logic [N_MASTERS-1:0] i_req,
  input  logic [GW-1:0]        i_last,
  output logic                 o_any,
  output logic [GW-1:0]        o_next
);

  int   w_idx;
  logic w_found;

  // Walk the N candidates starting at last+1; the last grant itself is
  // visited last so a lone requester can win repeatedly.
  always_comb begin
    o_any   = |i_req;
    o_next  = i_last;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 1; k <= N_MASTERS; k++) begin
      w_idx = (int'(i_last) + k) % N_MASTERS;
      if (!w_found && i_req[w_idx]) begin
        o_next  = GW'(w_idx);
        w_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sb_rr_arbiter.sv
// Shares one system-bus slave between N masters with round-robin arbitration,
// a latched command per transaction and a watchdog error response.
//
// Handshake: a master raises m_req_i and holds req/we/addr/wdata until it sees
// a one-cycle m_ready_o pulse; rdata and err are valid only in that cycle.
// Toward the slave, s_req_o stays high with a stable command until the cycle
// in which s_ready_i is sampled high (or the watchdog expires). There is
// always at least one IDLE cycle between transactions. busy_o mirrors the FSM
// state (1 = BUSY) for observation.
module sb_rr_arbiter
  import sb_arb_pkg::*;
#(
  parameter int                N_MASTERS = 2,
  parameter int                TIMEOUT   = 255,
  parameter logic [DATA_W-1:0] ERR_DATA  = ERR_DATA_DEFAULT,
  localparam int               GW        = idx_width(N_MASTERS)
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [N_MASTERS-1:0]              m_req_i,
  input  logic [N_MASTERS-1:0]              m_we_i,
  input  logic [N_MASTERS-1:0][ADDR_W-1:0]  m_addr_i,
  input  logic [N_MASTERS-1:0][DATA_W-1:0]  m_wdata_i,
  output logic [N_MASTERS-1:0][DATA_W-1:0]  m_rdata_o,
  output logic [N_MASTERS-1:0]              m_ready_o,
  output logic [N_MASTERS-1:0]              m_err_o,
  output logic                              s_req_o,
  output logic                              s_we_o,
  output logic [ADDR_W-1:0]                 s_addr_o,
  output logic [DATA_W-1:0]                 s_wdata_o,
  input  logic [DATA_W-1:0]                 s_rdata_i,
  input  logic                              s_ready_i,
  output logic [GW-1:0]                     grant_o,
  output logic                              busy_o
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [GW-1:0] LAST_RST = GW'(N_MASTERS - 1);

  arb_state_e      r_state,      w_state_nxt;
  logic [GW-1:0]   r_last_grant, w_last_grant_nxt;
  logic [GW-1:0]   r_grant,      w_grant_nxt;
  bus_cmd_t        r_cmd,        w_cmd_nxt;
  logic [TW-1:0]   r_tcnt,       w_tcnt_nxt;

  logic            w_any_req;
  logic [GW-1:0]   w_pick;
  logic            w_busy;
  logic            w_expire;
  logic            w_ok_done;
  logic            w_to_done;
  logic            w_done;

  rr_picker #(
    .N_MASTERS (N_MASTERS)
  ) u_picker (
    .i_req  (m_req_i),
    .i_last (r_last_grant),
    .o_any  (w_any_req),
    .o_next (w_pick)
  );

  // Completion qualifiers: slave ready wins over the watchdog in the same
  // cycle, and nothing completes while reset is asserted.
  always_comb begin
    w_busy    = (r_state == ST_BUSY);
    w_expire  = (TIMEOUT > 0) && (int'(r_tcnt) == TIMEOUT - 1);
    w_ok_done = w_busy && rst_ni && s_ready_i;
    w_to_done = w_busy && rst_ni && !s_ready_i && w_expire;
    w_done    = w_ok_done || w_to_done;
  end

  // Next-state, command capture, watchdog and grant bookkeeping.
  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_grant_nxt      = r_grant;
    w_cmd_nxt        = r_cmd;
    w_tcnt_nxt       = r_tcnt;
    case (r_state)
      ST_IDLE: begin
        w_tcnt_nxt = '0;
        if (w_any_req) begin
          w_grant_nxt     = w_pick;
          w_cmd_nxt.we    = m_we_i[w_pick];
          w_cmd_nxt.addr  = m_addr_i[w_pick];
          w_cmd_nxt.wdata = m_wdata_i[w_pick];
          w_state_nxt     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (w_done) begin
          w_last_grant_nxt = r_grant;
          w_tcnt_nxt       = '0;
          w_state_nxt      = ST_IDLE;
        end else if (TIMEOUT > 0) begin
          w_tcnt_nxt = r_tcnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state      <= ST_IDLE;
      r_last_grant <= LAST_RST;
      r_grant      <= '0;
      r_cmd        <= '0;
      r_tcnt       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_grant      <= w_grant_nxt;
      r_cmd        <= w_cmd_nxt;
      r_tcnt       <= w_tcnt_nxt;
    end
  end

  // Slave side: the latched command while BUSY, all zero while IDLE.
  always_comb begin
    s_req_o   = 1'b0;
    s_we_o    = 1'b0;
    s_addr_o  = '0;
    s_wdata_o = '0;
    if (w_busy) begin
      s_req_o   = 1'b1;
      s_we_o    = r_cmd.we;
      s_addr_o  = r_cmd.addr;
      s_wdata_o = r_cmd.wdata;
    end
  end

  // Master side: only the granted master sees ready/err/rdata, and only in
  // its completion cycle; read data passes straight through from the slave.
  always_comb begin
    m_ready_o = '0;
    m_err_o   = '0;
    m_rdata_o = '0;
    if (w_ok_done) begin
      m_ready_o[r_grant] = 1'b1;
      m_rdata_o[r_grant] = s_rdata_i;
    end else if (w_to_done) begin
      m_ready_o[r_grant] = 1'b1;
      m_err_o[r_grant]   = 1'b1;
      m_rdata_o[r_grant] = ERR_DATA;
    end
  end

  // Observation outputs.
  always_comb begin
    grant_o = r_grant;
    busy_o  = w_busy;
  end

endmodule
